// File: rtl/mem_tag_responder.sv
// Tagged-bus memory responder: combinational accept/tag, fixed-LATENCY load return.
// Optional MEM_BACKPRESSURE_EN refuses every request one cycle in four.
`ifndef XLEN
`define XLEN 32
`endif

module mem_tag_responder #(
  parameter int LATENCY      = 4,
  parameter int MEM_DEPTH_DW = 8192
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        proc2mem_command,
  input  logic [`XLEN-1:0]  proc2mem_addr,
  input  logic [63:0]       proc2mem_data,
  output logic [3:0]        mem2proc_response,
  output logic [63:0]       mem2proc_data,
  output logic [3:0]        mem2proc_tag
);

  localparam int              IDX_W     = $clog2(MEM_DEPTH_DW);
  localparam int              DW_W      = `XLEN - 3;
  localparam logic [DW_W-1:0] DEPTH_L   = DW_W'(MEM_DEPTH_DW);
  localparam logic [1:0]      BUS_LOAD  = 2'd1;
  localparam logic [1:0]      BUS_STORE = 2'd2;

  logic [63:0]      unified_memory [MEM_DEPTH_DW];
  logic [3:0]       tag_pipe_r     [LATENCY];
  logic [63:0]      data_pipe_r    [LATENCY];
  logic [3:0]       next_tag_r;
  logic             is_load_s;
  logic             is_store_s;
  logic             in_range_s;
  logic             throttled_s;
  logic             accept_s;
  logic [DW_W-1:0]  dw_addr_s;
  logic [IDX_W-1:0] idx_s;
  logic             unused_addr_lsb_s;

  assign dw_addr_s         = proc2mem_addr[`XLEN-1:3];
  assign idx_s             = proc2mem_addr[IDX_W+2:3];
  assign unused_addr_lsb_s = ^proc2mem_addr[2:0];

`ifdef MEM_BACKPRESSURE_EN
  logic [1:0] throttle_r;

  // Free-running throttle phase; phase 3 refuses all requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      throttle_r <= 2'd0;
    end else begin
      throttle_r <= throttle_r + 2'd1;
    end
  end

  assign throttled_s = (throttle_r == 2'd3);
`else
  assign throttled_s = 1'b0;
`endif

  // Decode the command and decide acceptance in the same cycle.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    case (proc2mem_command)
      BUS_LOAD:  is_load_s  = 1'b1;
      BUS_STORE: is_store_s = 1'b1;
      default: begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
      end
    endcase
    in_range_s = (dw_addr_s < DEPTH_L);
    accept_s   = (is_load_s || is_store_s) && !reset && in_range_s && !throttled_s;
    if (accept_s) begin
      mem2proc_response = next_tag_r;
    end else begin
      mem2proc_response = 4'd0;
    end
  end

  // Storage array: deliberately outside reset so preloaded and stored data survive.
  always_ff @(posedge clock) begin
    if (accept_s && is_store_s) begin
      unified_memory[idx_s] <= proc2mem_data;
    end
  end

  // Tag counter and return pipeline; stores occupy a slot with tag 0 and data 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      next_tag_r <= 4'd1;
      for (int i = 0; i < LATENCY; i++) begin
        tag_pipe_r[i]  <= 4'd0;
        data_pipe_r[i] <= 64'd0;
      end
    end else begin
      if (accept_s) begin
        next_tag_r <= (next_tag_r == 4'd15) ? 4'd1 : next_tag_r + 4'd1;
      end
      if (accept_s && is_load_s) begin
        tag_pipe_r[0]  <= next_tag_r;
        data_pipe_r[0] <= unified_memory[idx_s];
      end else begin
        tag_pipe_r[0]  <= 4'd0;
        data_pipe_r[0] <= 64'd0;
      end
      for (int i = 1; i < LATENCY; i++) begin
        tag_pipe_r[i]  <= tag_pipe_r[i-1];
        data_pipe_r[i] <= data_pipe_r[i-1];
      end
    end
  end

  // Gate with reset so nothing stale escapes during the reset cycle itself.
  assign mem2proc_tag  = reset ? 4'd0  : tag_pipe_r[LATENCY-1];
  assign mem2proc_data = reset ? 64'd0 : data_pipe_r[LATENCY-1];

endmodule

// File: tb/tb_mem_tag_responder.sv
// Scoreboard bench for mem_tag_responder: expected returns queued at issue, compared at completion.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_tag_responder;

  localparam int LATENCY = 4;
  localparam int DEPTH   = 8192;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        proc2mem_command = 2'd0;
  logic [`XLEN-1:0]  proc2mem_addr = '0;
  logic [63:0]       proc2mem_data = 64'd0;
  logic [3:0]        mem2proc_response;
  logic [63:0]       mem2proc_data;
  logic [3:0]        mem2proc_tag;

  mem_tag_responder #(.LATENCY(LATENCY), .MEM_DEPTH_DW(DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } ret_t;

  ret_t        sb_q[$];
  logic [63:0] mdl_mem [int];
  logic [3:0]  mdl_tag = 4'd1;
  logic [1:0]  mdl_thr = 2'd0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, obs, exp_v);
    end
  endtask

  // One bus cycle: drive, check response and completion, then advance the model.
  task automatic step(input logic [1:0] cmd, input logic [`XLEN-1:0] addr,
                      input logic [63:0] wdata, input logic rst);
    logic        acc;
    logic        thr;
    logic [3:0]  exp_tag;
    logic [63:0] exp_data;
    ret_t        r;
    int          idx;
    @(negedge clock);
    reset            = rst;
    proc2mem_command = cmd;
    proc2mem_addr    = addr;
    proc2mem_data    = wdata;
`ifdef MEM_BACKPRESSURE_EN
    thr = (mdl_thr == 2'd3);
`else
    thr = 1'b0;
`endif
    idx = int'(addr >> 3);
    acc = (cmd == 2'd1 || cmd == 2'd2) && !rst && (idx < DEPTH) && !thr;
    #1;
    check_eq("response", {60'd0, mem2proc_response}, acc ? {60'd0, mdl_tag} : 64'd0);
    exp_tag  = 4'd0;
    exp_data = 64'd0;
    if (!rst && sb_q.size() > 0 && sb_q[0].due == cyc) begin
      r        = sb_q.pop_front();
      exp_tag  = r.tag;
      exp_data = r.data;
    end
    check_eq("ret_tag", {60'd0, mem2proc_tag}, {60'd0, exp_tag});
    check_eq("ret_data", mem2proc_data, exp_data);
    if (rst) begin
      sb_q.delete();
      mdl_tag = 4'd1;
      mdl_thr = 2'd0;
    end else begin
      mdl_thr = mdl_thr + 2'd1;
      if (acc) begin
        if (cmd == 2'd1) begin
          r.due  = cyc + LATENCY;
          r.tag  = mdl_tag;
          r.data = mdl_mem[idx];
          sb_q.push_back(r);
        end else begin
          mdl_mem[idx] = wdata;
        end
        mdl_tag = (mdl_tag == 4'd15) ? 4'd1 : mdl_tag + 4'd1;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'd0, '0, 64'd0, 1'b0);
  endtask

  initial begin
    logic [63:0] pat;
    // Reset state
    step(2'd1, '0, 64'd0, 1'b1);
    step(2'd0, '0, 64'd0, 1'b1);

    // Preload 20 doublewords through the bus
    for (int i = 0; i < 20; i++) begin
      pat = (i == 0) ? 64'h0000_0013_0000_0093
                     : {32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 ^ 32'(i)};
      step(2'd2, `XLEN'(8 * i), pat, 1'b0);
    end
    idle(2);

    // Single load after reset: tag 1, data back LATENCY cycles later
    step(2'd0, '0, 64'd0, 1'b1);
    step(2'd1, '0, 64'd0, 1'b0);
    idle(LATENCY + 1);

    // Back-to-back loads across the tag wrap
    step(2'd0, '0, 64'd0, 1'b1);
    for (int i = 0; i < 20; i++) step(2'd1, `XLEN'(8 * i), 64'd0, 1'b0);
    idle(LATENCY + 1);

    // Old-data load, store, new-data load; command 3 must not write
    step(2'd1, `XLEN'(32'h40), 64'd0, 1'b0);
    step(2'd2, `XLEN'(32'h40), 64'hDEAD_BEEF_0000_0001, 1'b0);
    step(2'd1, `XLEN'(32'h40), 64'd0, 1'b0);
    step(2'd3, `XLEN'(32'h40), 64'h1111_2222_3333_4444, 1'b0);
    step(2'd1, `XLEN'(32'h40), 64'd0, 1'b0);
    idle(LATENCY + 1);

    // Out-of-range load refused, next in-range load keeps the tag sequence
    step(2'd1, `XLEN'(32'h0001_0000), 64'd0, 1'b0);
    step(2'd2, `XLEN'(32'h0001_0008), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    step(2'd1, `XLEN'(32'h8), 64'd0, 1'b0);
    idle(LATENCY + 1);

    // Reset with loads in flight: no stale returns, tag restarts, memory kept
    step(2'd1, `XLEN'(32'h0), 64'd0, 1'b0);
    step(2'd1, `XLEN'(32'h8), 64'd0, 1'b0);
    step(2'd1, `XLEN'(32'h10), 64'd0, 1'b1);
    idle(LATENCY + 2);
    step(2'd1, `XLEN'(32'h40), 64'd0, 1'b0);
    step(2'd1, `XLEN'(32'h0), 64'd0, 1'b0);
    idle(LATENCY + 1);

    // Load held every cycle from reset (throttle pattern when enabled)
    step(2'd0, '0, 64'd0, 1'b1);
    for (int i = 0; i < 12; i++) step(2'd1, `XLEN'(8 * (i % 20)), 64'd0, 1'b0);
    idle(LATENCY + 1);

    // Random mix of loads, stores and idle within the preloaded region
    for (int i = 0; i < 30; i++) begin
      step(2'($urandom_range(0, 3)), `XLEN'(8 * $urandom_range(0, 19)),
           {$urandom, $urandom}, 1'b0);
    end
    idle(LATENCY + 1);

    check_eq("drain", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
